// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM Wishbone arbiter.
// Holds the master count, the arbiter state encoding and the round-robin
// choice function that the picker sub-module wraps.
package sdram_arb_pkg;

   localparam int NMASTERS = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      FLUSH = 2'd2
   } arb_state_t;

   // Round-robin choice: scan last+1, last+2, last (mod 3) and return the
   // first requester as a one-hot vector, or zero when nobody requests.
   // A last value of 3 never occurs and is treated like 2 (m0 first).
   function automatic logic [2:0] rr_next(input logic [2:0] req, input logic [1:0] last);
      logic [2:0] pick;
      pick = 3'b000;
      case (last)
         2'd0: begin
            if (req[1])      pick = 3'b010;
            else if (req[2]) pick = 3'b100;
            else if (req[0]) pick = 3'b001;
         end
         2'd1: begin
            if (req[2])      pick = 3'b100;
            else if (req[0]) pick = 3'b001;
            else if (req[1]) pick = 3'b010;
         end
         default: begin
            if (req[0])      pick = 3'b001;
            else if (req[1]) pick = 3'b010;
            else if (req[2]) pick = 3'b100;
         end
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Purely combinational three-way round-robin chooser.
// Given the request vector and the index of the most recent grant it
// returns the next one-hot grant; shared with other bus arbiters.
module arb_rr_picker
   import sdram_arb_pkg::*;
(
   input  logic [NMASTERS-1:0] req,
   input  logic [1:0]          last,
   output logic [NMASTERS-1:0] grant
);

   // next owner is the first requester after the previous one
   assign grant = rr_next(req, last);

endmodule

// File: rtl/sdram_arbiter.sv
// Three-master round-robin Wishbone arbiter in front of the SDRAM
// cache/controller slave port (m0 CPU, m1 video/DMA, m2 spare DMA).
// A grant is held for the owner's whole cyc burst so cache-line refills
// never interleave, and every release is followed by one idle cycle.
// Optional macro ARB_TIMEOUT_EN adds a stall watchdog: after TIMEOUT
// cycles of stb without ack the owner gets a one-cycle m_err_o pulse and
// the arbiter parks in FLUSH until that master drops cyc.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int AW      = 25,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1024
)
(
   input  logic                       sysclock,
   input  logic                       rst_i,
   input  logic [NMASTERS-1:0]        m_cyc_i,
   input  logic [NMASTERS-1:0]        m_stb_i,
   input  logic [NMASTERS-1:0]        m_we_i,
   input  logic [NMASTERS*AW-1:0]     m_adr_i,
   input  logic [NMASTERS*DW-1:0]     m_dat_i,
   input  logic [NMASTERS*DW/8-1:0]   m_sel_i,
   output logic [NMASTERS-1:0]        m_ack_o,
   output logic [NMASTERS-1:0]        m_err_o,
   output logic [DW-1:0]              m_dat_o,
   output logic                       s_cyc_o,
   output logic                       s_stb_o,
   output logic                       s_we_o,
   output logic [AW-1:0]              s_adr_o,
   output logic [DW-1:0]              s_dat_o,
   output logic [DW/8-1:0]            s_sel_o,
   input  logic [DW-1:0]              s_dat_i,
   input  logic                       s_ack_i,
   output logic [NMASTERS-1:0]        grant_o
);

   localparam int SW = DW / 8;

   arb_state_t           state;
   logic [NMASTERS-1:0]  grant;
   logic [1:0]           last;
   logic [NMASTERS-1:0]  pick;
   logic [1:0]           gidx;
   logic                 in_grant;
   logic                 sel_cyc;
   logic                 sel_stb;
   logic                 sel_we;
   logic [AW-1:0]        sel_adr;
   logic [DW-1:0]        sel_dat;
   logic [SW-1:0]        sel_sel;

`ifdef ARB_TIMEOUT_EN
   localparam int              TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);
   logic [TW-1:0]        timer;
   logic [NMASTERS-1:0]  err_q;
`else
   // TIMEOUT has no effect when the watchdog is compiled out
   localparam int unused_timeout = TIMEOUT;
`endif

   arb_rr_picker u_picker (
      .req   (m_cyc_i),
      .last  (last),
      .grant (pick)
   );

   // convert the one-hot grant into the index remembered as "last"
   always_comb begin
      gidx = 2'd0;
      if (grant[1])      gidx = 2'd1;
      else if (grant[2]) gidx = 2'd2;
   end

   // steer the granted master's request fields toward the slave
   always_comb begin
      sel_adr = '0;
      sel_dat = '0;
      sel_sel = '0;
      for (int k = 0; k < NMASTERS; k++) begin
         if (grant[k]) begin
            sel_adr = m_adr_i[k*AW +: AW];
            sel_dat = m_dat_i[k*DW +: DW];
            sel_sel = m_sel_i[k*SW +: SW];
         end
      end
   end

   assign sel_cyc  = |(m_cyc_i & grant);
   assign sel_stb  = |(m_stb_i & grant);
   assign sel_we   = |(m_we_i & grant);
   assign in_grant = (state == GRANT);

   assign s_cyc_o  = in_grant & sel_cyc;
   assign s_stb_o  = s_cyc_o & sel_stb;
   assign s_we_o   = in_grant & sel_we;
   assign s_adr_o  = in_grant ? sel_adr : '0;
   assign s_dat_o  = in_grant ? sel_dat : '0;
   assign s_sel_o  = in_grant ? sel_sel : '0;
   assign m_ack_o  = in_grant ? (grant & {NMASTERS{s_ack_i}}) : '0;
   assign m_dat_o  = s_dat_i;
   assign grant_o  = in_grant ? grant : '0;

`ifdef ARB_TIMEOUT_EN
   assign m_err_o  = err_q;
`else
   assign m_err_o  = '0;
`endif

   // arbitration FSM: pick in IDLE, hold through the burst, park in FLUSH after a timeout
   always_ff @(posedge sysclock or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         grant <= '0;
         last  <= 2'd2;
`ifdef ARB_TIMEOUT_EN
         timer <= '0;
         err_q <= '0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         err_q <= '0;
`endif
         case (state)
            IDLE: begin
               if (|m_cyc_i) begin
                  grant <= pick;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (!sel_cyc) begin
                  last  <= gidx;
                  grant <= '0;
                  state <= IDLE;
`ifdef ARB_TIMEOUT_EN
                  timer <= '0;
`endif
               end
`ifdef ARB_TIMEOUT_EN
               else if (s_stb_o && !s_ack_i) begin
                  if (timer == TLAST) begin
                     err_q <= grant;
                     timer <= '0;
                     state <= FLUSH;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end else begin
                  timer <= '0;
               end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            FLUSH: begin
               if (!sel_cyc) begin
                  last  <= gidx;
                  grant <= '0;
                  state <= IDLE;
               end
            end
`endif
            default: begin
               grant <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter.
// A behavioural ownership model (owner index, last owner, stall count)
// predicts every slave-side and master-side output each cycle, while
// directed scenarios add hand-computed literal checks.
// Build with +define+ARB_TIMEOUT_EN to exercise the watchdog (TIMEOUT=16).
module tb_sdram_arbiter;

   localparam int AW = 25;
   localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic          sysclock;
   logic          rst_i;
   logic [2:0]    m_cyc_i;
   logic [2:0]    m_stb_i;
   logic [2:0]    m_we_i;
   logic [3*AW-1:0] m_adr_i;
   logic [3*DW-1:0] m_dat_i;
   logic [11:0]   m_sel_i;
   logic [2:0]    m_ack_o;
   logic [2:0]    m_err_o;
   logic [DW-1:0] m_dat_o;
   logic          s_cyc_o;
   logic          s_stb_o;
   logic          s_we_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic [3:0]    s_sel_o;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i;
   logic [2:0]    grant_o;

   int total = 0;
   int bad   = 0;

   sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .sysclock (sysclock),
      .rst_i    (rst_i),
      .m_cyc_i  (m_cyc_i),
      .m_stb_i  (m_stb_i),
      .m_we_i   (m_we_i),
      .m_adr_i  (m_adr_i),
      .m_dat_i  (m_dat_i),
      .m_sel_i  (m_sel_i),
      .m_ack_o  (m_ack_o),
      .m_err_o  (m_err_o),
      .m_dat_o  (m_dat_o),
      .s_cyc_o  (s_cyc_o),
      .s_stb_o  (s_stb_o),
      .s_we_o   (s_we_o),
      .s_adr_o  (s_adr_o),
      .s_dat_o  (s_dat_o),
      .s_sel_o  (s_sel_o),
      .s_dat_i  (s_dat_i),
      .s_ack_i  (s_ack_i),
      .grant_o  (grant_o)
   );

   // free-running clock, 10 time units per cycle
   initial sysclock = 1'b0;
   always #5 sysclock = ~sysclock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int k, input logic cyc, input logic stb, input logic we,
                                input logic [AW-1:0] adr, input logic [DW-1:0] dat);
      m_cyc_i[k]           = cyc;
      m_stb_i[k]           = stb;
      m_we_i[k]            = we;
      m_adr_i[k*AW +: AW]  = adr;
      m_dat_i[k*DW +: DW]  = dat;
      m_sel_i[k*4 +: 4]    = stb ? 4'hF : 4'h0;
   endtask

   // advance to 2 time units after the next rising edge
   task automatic step();
      @(posedge sysclock);
      #2;
   endtask

   task automatic doReset();
      rst_i   = 1'b1;
      m_cyc_i = '0;
      m_stb_i = '0;
      m_we_i  = '0;
      m_adr_i = '0;
      m_dat_i = '0;
      m_sel_i = '0;
      s_ack_i = 1'b0;
      s_dat_i = '0;
      step();
      step();
      rst_i = 1'b0;
   endtask

   // called in the first granted cycle of master k: one-beat ack, release, check the gap
   task automatic serve(input int k, input bit rereq);
      step();
      s_ack_i = 1'b1;
      step();
      s_ack_i = 1'b0;
      applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
      step();
      checkOutput("idle gap", {29'd0, grant_o}, 32'd0);
      if (rereq) applyStimulus(k, 1'b1, 1'b1, 1'b1, 25'(k * 16 + 1), 32'(k));
      step();
   endtask

   // behavioural model: who owns the slave, who had it last, how long it has stalled
   int own    = -1;
   int lastm  = 2;
   int stall  = 0;
   int errm   = -1;
   bit flushm = 1'b0;
   int mc;

   always @(posedge sysclock or posedge rst_i) begin
      if (rst_i) begin
         own = -1; lastm = 2; stall = 0; errm = -1; flushm = 1'b0;
      end else begin
         errm = -1;
         if (own < 0) begin
            stall = 0;
            for (int i = 1; i <= 3; i++) begin
               mc = (lastm + i) % 3;
               if (own < 0 && m_cyc_i[mc]) own = mc;
            end
         end else if (!m_cyc_i[own]) begin
            lastm = own; own = -1; flushm = 1'b0; stall = 0;
         end else if (!flushm) begin
            if (m_stb_i[own] && !s_ack_i) begin
               stall++;
`ifdef ARB_TIMEOUT_EN
               if (stall == TO) begin
                  flushm = 1'b1; errm = own; stall = 0;
               end
`endif
            end else begin
               stall = 0;
            end
         end
      end
   end

   // compare the DUT against the model in the middle of every cycle
   logic        e_act;
   logic [2:0]  e_grant, e_ack, e_err;
   logic        e_cyc, e_stb, e_we;
   logic [AW-1:0] e_adr;
   logic [DW-1:0] e_dat;
   logic [3:0]  e_sel;

   always @(negedge sysclock) begin
      e_act   = (own >= 0) && !flushm;
      e_grant = '0; e_ack = '0; e_err = '0;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_adr = '0; e_dat = '0; e_sel = '0;
      if (e_act) begin
         e_grant[own] = 1'b1;
         e_cyc = m_cyc_i[own];
         e_stb = m_cyc_i[own] && m_stb_i[own];
         e_we  = m_we_i[own];
         e_adr = m_adr_i[own*AW +: AW];
         e_dat = m_dat_i[own*DW +: DW];
         e_sel = m_sel_i[own*4 +: 4];
         if (s_ack_i) e_ack[own] = 1'b1;
      end
      if (errm >= 0) e_err[errm] = 1'b1;
      checkOutput("model ctrl", {20'd0, grant_o, s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o},
                                {20'd0, e_grant, e_cyc, e_stb, e_we, e_ack, e_err});
      checkOutput("model s_adr", {7'd0, s_adr_o}, {7'd0, e_adr});
      checkOutput("model s_dat", s_dat_o, e_dat);
      checkOutput("model s_sel", {28'd0, s_sel_o}, {28'd0, e_sel});
      checkOutput("model m_dat", m_dat_o, s_dat_i);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      // reset state, with m0 already asking: nothing may reach the slave
      rst_i = 1'b1;
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      s_ack_i = 1'b0; s_dat_i = '0;
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 25'h10, '0);
      step();
      step();
      checkOutput("reset grant", {29'd0, grant_o}, 32'd0);
      checkOutput("reset s_cyc", {31'd0, s_cyc_o}, 32'd0);
      checkOutput("reset s_stb", {31'd0, s_stb_o}, 32'd0);
      checkOutput("reset m_ack", {29'd0, m_ack_o}, 32'd0);
      checkOutput("reset m_err", {29'd0, m_err_o}, 32'd0);

      // single m0 read, slave answers three cycles after the request
      $display("[TB] single read from m0");
      doReset();
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 25'h000010, '0);
      step();
      checkOutput("t1 grant", {29'd0, grant_o}, 32'd1);
      checkOutput("t1 s_adr", {7'd0, s_adr_o}, 32'h10);
      step();
      step();
      s_ack_i = 1'b1;
      s_dat_i = 32'hDEADBEEF;
      #1;
      checkOutput("t1 m_ack", {29'd0, m_ack_o}, 32'd1);
      checkOutput("t1 m_dat", m_dat_o, 32'hDEADBEEF);
      step();
      s_ack_i = 1'b0;
      s_dat_i = '0;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
      step();
      step();

      // all three hold cyc: strict rotation 001, 010, 100, then m0 again
      $display("[TB] three-way rotation");
      doReset();
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 25'h001, 32'h11111111);
      applyStimulus(1, 1'b1, 1'b1, 1'b1, 25'h011, 32'h22222222);
      applyStimulus(2, 1'b1, 1'b1, 1'b1, 25'h021, 32'h33333333);
      step();
      checkOutput("t2 grant 1st", {29'd0, grant_o}, 32'd1);
      serve(0, 1'b1);
      checkOutput("t2 grant 2nd", {29'd0, grant_o}, 32'd2);
      serve(1, 1'b0);
      checkOutput("t2 grant 3rd", {29'd0, grant_o}, 32'd4);
      serve(2, 1'b0);
      checkOutput("t2 grant 4th", {29'd0, grant_o}, 32'd1);
      serve(0, 1'b0);

      // four-beat m0 burst, m1 shows up at beat 2 and must wait
      $display("[TB] burst hold");
      doReset();
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 25'h0, 32'hA0);
      step();
      for (int b = 0; b < 4; b++) begin
         applyStimulus(0, 1'b1, 1'b1, 1'b1, 25'(b), 32'hA0 + 32'(b));
         s_ack_i = 1'b1;
         if (b == 2) applyStimulus(1, 1'b1, 1'b1, 1'b0, 25'h1ABCDE, '0);
         #1;
         checkOutput("t3 s_adr", {7'd0, s_adr_o}, 32'(b));
         checkOutput("t3 grant", {29'd0, grant_o}, 32'd1);
         step();
      end
      s_ack_i = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
      step();
      checkOutput("t3 gap", {29'd0, grant_o}, 32'd0);
      step();
      checkOutput("t3 m1 grant", {29'd0, grant_o}, 32'd2);
      checkOutput("t3 m1 adr", {7'd0, s_adr_o}, 32'h1ABCDE);
      serve(1, 1'b0);

      // asynchronous reset in the middle of a write
      $display("[TB] async reset mid-write");
      doReset();
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 25'h55, 32'h12345678);
      step();
      #1;
      checkOutput("t4 s_cyc before", {31'd0, s_cyc_o}, 32'd1);
      rst_i = 1'b1;
      #1;
      checkOutput("t4 s_cyc after", {31'd0, s_cyc_o}, 32'd0);
      checkOutput("t4 grant after", {29'd0, grant_o}, 32'd0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
      step();
      rst_i = 1'b0;
      step();
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 25'h77, '0);
      step();
      checkOutput("t4 m1 grant", {29'd0, grant_o}, 32'd2);
      serve(1, 1'b0);

      // m2 talks to a slave that never acks, m0 waits behind it
      $display("[TB] hung slave on m2");
      doReset();
      applyStimulus(2, 1'b1, 1'b1, 1'b0, 25'h1FFFFFF, '0);
      step();
      checkOutput("t5 grant", {29'd0, grant_o}, 32'd4);
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 25'h3, '0);
`ifdef ARB_TIMEOUT_EN
      n = 0;
      while (m_err_o == 3'b000 && n < 40) begin
         step();
         n++;
      end
      checkOutput("t5 err delay", 32'(n), 32'd16);
      checkOutput("t5 err", {29'd0, m_err_o}, 32'd4);
      checkOutput("t5 s_cyc at err", {31'd0, s_cyc_o}, 32'd0);
      step();
      checkOutput("t5 err pulse", {29'd0, m_err_o}, 32'd0);
      checkOutput("t5 s_cyc flush", {31'd0, s_cyc_o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("t5 flush hold", {29'd0, grant_o}, 32'd0);
      end
`else
      n = 0;
      for (int i = 0; i < 110; i++) begin
         step();
         checkOutput("t5 hang hold", {26'd0, grant_o, m_err_o}, {26'd0, 3'b100, 3'b000});
         n++;
      end
`endif
      applyStimulus(2, 1'b0, 1'b0, 1'b0, '0, '0);
      step();
      step();
      checkOutput("t5 m0 grant", {29'd0, grant_o}, 32'd1);
      serve(0, 1'b0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
